// File: rtl/i2c_resp_pkg.sv
// ---------------------------------------------------------------------------
// i2c_resp_pkg
// Shared definitions for the I2C temperature-sensor responder.
//   state_t   : protocol FSM states.
//   BIT_CNT_W : width of the per-byte bit counter.
//   LAST_BIT  : counter value of the eighth bit of a byte.
//   RW_READ   : value of the R/W bit that selects a read transfer.
//   maj3      : 3-input majority vote. It is used only when the optional
//               I2C_GLITCH_FILTER_EN line filter is compiled in.
// ---------------------------------------------------------------------------
package i2c_resp_pkg;

    localparam int BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = {BIT_CNT_W{1'b1}};
    localparam logic RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        TX_BYTE,
        TX_ACK,
        RX_BYTE,
        RX_ACK,
        WAIT_STOP
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// ---------------------------------------------------------------------------
// i2c_line_cond
// Conditions the raw SCL/SDA pad levels for the responder FSM. One instance
// serves both lines, so START and STOP can be decoded from their relationship.
// Each line passes through SYNC_STAGES synchronizer flops (legal range 2..3).
// Each line then passes through an optional majority filter and a history flop
// that produces the edge strobes.
//
// Compile-time option:
//   I2C_GLITCH_FILTER_EN : when defined, each synchronized line goes through a
//                          3-sample majority filter. The filter rejects pulses
//                          of 1 clk or less and delays every strobe by 2 clk.
//
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   scl_i      : SCL pad level
//   sda_i      : SDA pad level
//   sda        : conditioned SDA level, time-aligned with the strobes
//   scl_rise   : 1-cycle strobe on the rising edge of conditioned SCL
//   scl_fall   : 1-cycle strobe on the falling edge of conditioned SCL
//   start_det  : 1-cycle strobe when SDA falls while SCL is high
//   stop_det   : 1-cycle strobe when SDA rises while SCL is high
// ---------------------------------------------------------------------------
module i2c_line_cond
    import i2c_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_lvl;
    logic                   sda_lvl;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   sda_rise;
    logic                   sda_fall;

    // The synchronizers reset to the idle bus level (high). This avoids fake
    // edges when reset is released on an idle bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_filt;
    logic       sda_filt;

    // Majority of {current, 1 ago, 2 ago}. A new level must be present in two
    // consecutive samples before the filter passes it on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
            scl_filt <= maj3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
            sda_filt <= maj3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
        end
    end

    assign scl_lvl = scl_filt;
    assign sda_lvl = sda_filt;
`else
    assign scl_lvl = scl_sync[SYNC_STAGES-1];
    assign sda_lvl = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_lvl;
            sda_prev <= sda_lvl;
        end
    end

    assign sda       = sda_lvl;
    assign scl_rise  =  scl_lvl & ~scl_prev;
    assign scl_fall  = ~scl_lvl &  scl_prev;
    assign sda_rise  =  sda_lvl & ~sda_prev;
    assign sda_fall  = ~sda_lvl &  sda_prev;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

endmodule

// File: rtl/i2c_temp_responder.sv
// ---------------------------------------------------------------------------
// i2c_temp_responder
// I2C target that emulates a 16-bit temperature sensor. It ACKs SLAVE_ADDR.
// On a read it returns temp_value MSB then LSB, and repeats the pair while the
// master keeps ACKing. The word is captured at the address match, so later
// changes to temp_value have no effect within that transfer. Written bytes are
// stored in cfg_reg. The target never stretches SCL.
//
// Compile-time option: I2C_GLITCH_FILTER_EN (see i2c_line_cond).
//
// Parameters:
//   SLAVE_ADDR  : 7-bit bus address (default 7'h48)
//   SYNC_STAGES : synchronizer depth on scl_i/sda_i (2..3)
//
// Ports:
//   clk, reset : system clock (at least 8x SCL), asynchronous active-high reset
//   scl_i      : SCL pad level
//   sda_i      : SDA pad level
//   sda_oe     : 1 pulls SDA low, 0 releases it (open drain)
//   temp_value : temperature word, [15:8] sent first
//   cfg_reg    : last byte written by the master
//   wr_valid   : 1-cycle pulse when cfg_reg updates
//   rd_done    : 1-cycle pulse when the ACK/NACK after a sent byte is sampled
//   busy       : high from address match until STOP or a non-matching address
// ---------------------------------------------------------------------------
module i2c_temp_responder
    import i2c_resp_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] temp_value,
    output logic [7:0]  cfg_reg,
    output logic        wr_valid,
    output logic        rd_done,
    output logic        busy
);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_line_cond #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_cond (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t               state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [6:0]           rx_shift;   // the 8th bit goes straight to its destination
    logic [7:0]           tx_shift;
    logic [15:0]          tx_word;
    logic                 tx_lsb;     // 1 while the LSB is being sent
    logic                 tx_first;   // bit 7 of tx_shift still has to be driven
    logic                 rw;

    // All outputs are registered. sda_oe changes only on a conditioned
    // scl_fall, or on START/STOP, so it never changes mid-bit while SCL is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sda_oe   <= 1'b0;
            cfg_reg  <= 8'h00;
            wr_valid <= 1'b0;
            rd_done  <= 1'b0;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            tx_word  <= '0;
            tx_lsb   <= 1'b0;
            tx_first <= 1'b0;
            rw       <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            rd_done  <= 1'b0;

            if (start_det) begin
                // Repeated START also lands here. busy is kept until the new
                // address has been judged.
                state    <= ADDR;
                bit_cnt  <= '0;
                sda_oe   <= 1'b0;
                rx_shift <= '0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;

                    ADDR: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[5:0], sda};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                // rx_shift holds address bits [7:1]; sda is R/W.
                                // The general call (address 0) is never ACKed.
                                if ((rx_shift == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00)) begin
                                    state   <= ADDR_ACK;
                                    busy    <= 1'b1;
                                    tx_word <= temp_value;
                                    rw      <= sda;
                                end else begin
                                    state <= WAIT_STOP;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        // The first fall starts the ACK bit. The second fall
                        // ends it and, on a read, already drives data bit 7.
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (rw == RW_READ) begin
                                state    <= TX_BYTE;
                                tx_shift <= tx_word[15:8];
                                tx_lsb   <= 1'b0;
                                tx_first <= 1'b0;
                                bit_cnt  <= '0;
                                sda_oe   <= ~tx_word[15];
                            end else begin
                                state   <= RX_BYTE;
                                bit_cnt <= '0;
                                sda_oe  <= 1'b0;
                            end
                        end
                    end

                    TX_BYTE: begin
                        if (scl_fall) begin
                            if (tx_first) begin
                                sda_oe   <= ~tx_shift[7];
                                tx_first <= 1'b0;
                            end else if (bit_cnt == LAST_BIT) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= TX_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[6];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    TX_ACK: begin
                        if (scl_rise) begin
                            rd_done <= 1'b1;
                            if (!sda) begin
                                // ACK: send the other half of the captured word,
                                // wrapping LSB -> MSB. The word is not captured again.
                                tx_lsb   <= ~tx_lsb;
                                tx_shift <= tx_lsb ? tx_word[15:8] : tx_word[7:0];
                                tx_first <= 1'b1;
                                state    <= TX_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WAIT_STOP;
                            end
                        end
                    end

                    RX_BYTE: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[5:0], sda};
                            if (bit_cnt == LAST_BIT) begin
                                cfg_reg  <= {rx_shift, sda};
                                wr_valid <= 1'b1;
                                bit_cnt  <= '0;
                                state    <= RX_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    RX_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= RX_BYTE;
                            end
                        end
                    end

                    WAIT_STOP: sda_oe <= 1'b0;

                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_temp_responder.md
Name: i2c_temp_responder

Overview:
- Synthesizable I2C target (responder) that emulates the temperature sensor the TopClock I2C master reads.
- Lets the master and display path run in a closed loop, on board or in simulation, without a physical sensor.
- Samples the open-drain SCL/SDA lines, decodes START/STOP/address, ACKs its own address, and returns a 16-bit temperature word MSB then LSB.
- Accepts written bytes as a configuration byte.

Parameters:
- SLAVE_ADDR, 7'h48, 7-bit address this target responds to.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (legal range 2..3).

Ports:
- clk  in  1  system clock; must be ≥8x SCL frequency.
- reset  in  1  asynchronous, active-high reset.
- scl_i  in  1  SCL line level (pad input).
- sda_i  in  1  SDA line level (pad input).
- sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain; pad ties output to 0).
- temp_value  in  16  temperature word; [15:8] sent first (MSB), [7:0] second (LSB).
- cfg_reg  out  8  last byte written by the master.
- wr_valid  out  1  one-cycle pulse when cfg_reg updates.
- rd_done  out  1  one-cycle pulse after each transmitted byte whose ACK/NACK was sampled.
- busy  out  1  high from address match until STOP or a START for another address.

Behaviour:
- Reset (async, any time, including mid-transfer): state IDLE, sda_oe=0, cfg_reg=8'h00, wr_valid=0, rd_done=0, busy=0, bit counter 0, shift regs 0. No bus activity is required to recover.
- Inputs pass through SYNC_STAGES flops, then one history flop for edge detection.
  - scl_rise / scl_fall / sda_rise / sda_fall are single-cycle strobes.
- START = sda_fall while synced SCL high; STOP = sda_rise while SCL high.
  - Both have priority over every state.
  - START (including repeated START) -> ADDR with bit count 0, sda_oe=0.
  - STOP -> IDLE, sda_oe=0, busy=0.
- Data is sampled on scl_rise. sda_oe changes only on the cycle after scl_fall, so it never changes while SCL is high.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first on scl_rise. After bit 8, compare [7:1] to SLAVE_ADDR.
    - Match -> ADDR_ACK, busy=1, latch temp_value into tx_word (snapshot; later changes are ignored until the next address phase).
    - Mismatch -> WAIT_STOP.
  - ADDR_ACK: on next scl_fall assert sda_oe=1; on the following scl_fall release. Go to TX_BYTE if R/W=1 (load MSB), else RX_BYTE.
  - TX_BYTE: on each scl_fall drive sda_oe = ~current bit, MSB first; 8 bits. After the 8th bit's scl_fall, release -> TX_ACK.
  - TX_ACK: sample SDA on scl_rise and pulse rd_done.
    - SDA=0 (ACK): load the other byte, toggling MSB->LSB->MSB (wrap, no re-snapshot) -> TX_BYTE.
    - SDA=1 (NACK): -> WAIT_STOP, sda_oe=0.
  - RX_BYTE: shift 8 bits on scl_rise -> RX_ACK. cfg_reg updates and wr_valid pulses on the cycle the 8th bit is sampled.
  - RX_ACK: drive ACK as in ADDR_ACK -> RX_BYTE (multiple writes allowed; last byte wins).
  - WAIT_STOP: sda_oe=0, ignore traffic until STOP/START.
- General call (address 0) is not acknowledged.
- No clock stretching: the target never holds SCL.
- A START occurring during a driven ACK/data bit releases sda_oe on the next cycle.

Optional Feature:
- Macro I2C_GLITCH_FILTER_EN.
  - When defined: each synced line passes through a 3-sample majority filter before edge detection, rejecting pulses ≤1 clk wide. This adds 2 clk latency to all edge strobes.
  - When undefined: no filter, direct sync-to-edge path.

Decomposition:
- Package i2c_resp_pkg: state enum (IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK, WAIT_STOP), BIT_CNT_W=3, RW_READ=1.
- One natural sub-module: i2c_line_cond (synchronizer, optional majority filter, edge strobes, START/STOP detect), instantiated twice-line-aware once.

Test Plan:
- Reset asserted mid TX_BYTE with sda_oe=1 -> sda_oe=0 and busy=0 in the same cycle (async); next START+0x91 is handled normally.
- temp_value=16'h1980; master START, 0x91, reads 2 bytes ACK/NACK -> target ACKs the address; bytes 0x19, 0x80 received; rd_done pulses twice; busy falls at STOP.
- Master START, 0x90, writes 0x5A, STOP -> two ACKs; cfg_reg=8'h5A with one wr_valid pulse.
- START, 0x93 (address 0x49) -> no ACK (SDA stays high at 9th clock); sda_oe=0 throughout; cfg_reg unchanged.
- temp_value=16'h1980, master reads 3 bytes (ACK, ACK, NACK); temp_value changes to 16'h2200 after the address phase -> data 0x19, 0x80, 0x19 (wrap, snapshot held).
- Write 0x90 then repeated START 0x91 read -> the repeated START returns to ADDR, and MSB/LSB are read correctly.
